// File: rtl/memory_port_arbiter_pkg.sv
// arb_pkg: FSM and owner encodings plus parameter defaults shared by the
// memory port arbiter and its wait timer.
package arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} owner_t;
    localparam int TIMEOUT_DEF = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: CPU, external requester and memory bus signals;
// the arbiter takes the slave side.
interface memory_port_arbiter_if;
    logic cpu_req, cpu_wr, busy;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic ext_req, ext_wr, ext_ack;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic mem_en, mem_wr, mem_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ext_req, ext_wr, ext_addr, ext_wdata,
        output mem_rdata, mem_ready,
        input cpu_rdata, busy, ext_rdata, ext_ack,
        input mem_en, mem_wr, mem_addr, mem_wdata, err
    );
    modport slave (
        input cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input ext_req, ext_wr, ext_addr, ext_wdata,
        input mem_rdata, mem_ready,
        output cpu_rdata, busy, ext_rdata, ext_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/memory_port_arbiter_wait_timer.sv
// wait_timer: counts memory wait cycles; reached fires on the cycle whose
// increment would bring the count to TIMEOUT.
module wait_timer
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic reached
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clock)
        if (reset || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    assign reached = enable && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin arbiter sharing one memory port between
// the CPU and an external requester, with a wait timeout.
module memory_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input logic clock,
    input logic reset,
    memory_port_arbiter_if.slave bus
);
    state_t state, state_nxt;
    owner_t owner, last_grant, winner;
    logic grant, done, timed_out, ext_wins;
    logic [31:0] rdata_new;
    // EXT wins when alone, or on a tie when the CPU was granted last
    assign ext_wins = bus.ext_req && (!bus.cpu_req || last_grant == OWN_CPU);
    assign winner = ext_wins ? OWN_EXT : OWN_CPU;
    assign grant = state == IDLE && (bus.cpu_req || bus.ext_req);
    assign done = state == ACCESS && (bus.mem_ready || timed_out);
    assign rdata_new = bus.mem_ready ? bus.mem_rdata : ERR_DATA;
    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (grant),
        .enable  (state == ACCESS && !bus.mem_ready),
        .reached (timed_out)
    );
    always_ff @(posedge clock)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = grant ? ACCESS : done ? RESP : (state == RESP) ? IDLE : state;
    end
    assign bus.mem_en = state == ACCESS;
    assign bus.ext_ack = state == RESP && owner == OWN_EXT;
    assign bus.busy = bus.cpu_req && !(state == RESP && owner == OWN_CPU);
    always_ff @(posedge clock)
        if (reset) begin
            owner <= OWN_CPU;
            last_grant <= OWN_EXT;
            bus.err <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ext_rdata <= '0;
            bus.mem_wr <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (grant) begin
                owner <= winner;
                last_grant <= winner;
                bus.mem_wr <= ext_wins ? bus.ext_wr : bus.cpu_wr;
                bus.mem_addr <= ext_wins ? bus.ext_addr : bus.cpu_addr;
                bus.mem_wdata <= ext_wins ? bus.ext_wdata : bus.cpu_wdata;
            end
            if (done && timed_out) bus.err <= 1'b1;
            if (done && !bus.mem_wr && owner == OWN_CPU) bus.cpu_rdata <= rdata_new;
            if (done && !bus.mem_wr && owner == OWN_EXT) bus.ext_rdata <= rdata_new;
        end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed and randomized transfers checked against a
// transaction-level model of arbitration, memory contents and responses.
module tb_memory_port_arbiter;
    localparam int TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    memory_port_arbiter_if bus();
    memory_port_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    // Requester model: index 0 is the CPU, index 1 the external requester
    logic pend[2];
    logic wr[2];
    logic [31:0] addr[2], wdata[2], rdata_exp[2];
    logic [31:0] mem[logic [31:0]];
    int last;
    logic err_exp;
    logic drop_ok;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction
    task automatic drive();
        bus.cpu_req = pend[0];
        bus.cpu_wr = wr[0];
        bus.cpu_addr = addr[0];
        bus.cpu_wdata = wdata[0];
        bus.ext_req = pend[1];
        bus.ext_wr = wr[1];
        bus.ext_addr = addr[1];
        bus.ext_wdata = wdata[1];
    endtask
    task automatic set_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
        pend[r] = 1'b1;
        wr[r] = w;
        addr[r] = a;
        wdata[r] = d;
    endtask
    task automatic rand_req(input int r);
        set_req(r, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    endtask
    task automatic check_reset(input string tag);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_ext_ack"}, 32'(bus.ext_ack), 0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, "_ext_rdata"}, bus.ext_rdata, 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask
    // Entered at an IDLE negedge with requests driven; returns at the next IDLE negedge.
    // The memory answers after w wait cycles, or never within the timeout window.
    task automatic transfer(input int w);
        int win, n;
        logic hit;
        logic [31:0] d;
        win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        last = win;
        hit = w < TMO;
        n = hit ? w : TMO - 1;
        d = rd(addr[win]);
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        for (int i = 0; i <= n; i++) begin
            chk("mem_en", 32'(bus.mem_en), 1);
            chk("mem_addr", bus.mem_addr, addr[win]);
            chk("mem_wdata", bus.mem_wdata, wdata[win]);
            chk("mem_wr", 32'(bus.mem_wr), 32'(wr[win]));
            chk("busy_access", 32'(bus.busy), 32'(pend[0]));
            chk("ack_access", 32'(bus.ext_ack), 0);
            bus.mem_ready = i == w;
            bus.mem_rdata = (i == w) ? d : $urandom;
            if (drop_ok && $urandom_range(0, 7) == 0) begin
                pend[win] = 1'b0;
                drive();
            end
            @(negedge clock);
        end
        if (!wr[win]) rdata_exp[win] = hit ? d : ERR;
        else if (hit) mem[addr[win]] = wdata[win];
        if (!hit) err_exp = 1'b1;
        chk("resp_mem_en", 32'(bus.mem_en), 0);
        chk("ext_ack", 32'(bus.ext_ack), 32'(win == 1));
        chk("busy_resp", 32'(bus.busy), 32'(pend[0] && win != 0));
        chk("cpu_rdata", bus.cpu_rdata, rdata_exp[0]);
        chk("ext_rdata", bus.ext_rdata, rdata_exp[1]);
        chk("err", 32'(bus.err), 32'(err_exp));
        pend[win] = 1'b0;
        drive();
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge clock);
        chk("idle_mem_en", 32'(bus.mem_en), 0);
        chk("idle_ack", 32'(bus.ext_ack), 0);
    endtask
    initial begin
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0;
            wr[r] = 1'b0;
            addr[r] = '0;
            wdata[r] = '0;
            rdata_exp[r] = '0;
        end
        last = 1;
        err_exp = 1'b0;
        drop_ok = 1'b0;
        drive();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clock);
        check_reset("reset");
        reset = 1'b0;
        // Simultaneous requests straight out of reset: CPU first, then EXT
        set_req(0, 1'b0, 32'h80, 32'h1111_1111);
        set_req(1, 1'b0, 32'h100, 32'h2222_2222);
        drive();
        transfer(0);
        transfer(1);
        // Both held: grants alternate
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++) if (!pend[r]) rand_req(r);
            drive();
            transfer($urandom_range(0, 2));
        end
        // Zero-wait CPU read
        mem[32'h40] = 32'h1234_5678;
        set_req(0, 1'b0, 32'h40, 32'h0);
        drive();
        transfer(0);
        // EXT write with three wait cycles
        set_req(1, 1'b1, 32'h100, 32'hA5A5_A5A5);
        drive();
        transfer(3);
        drop_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 1) == 1) rand_req(r);
            if (!pend[0] && !pend[1]) rand_req($urandom_range(0, 1));
            drive();
            transfer(($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3));
        end
        drop_ok = 1'b0;
        // CPU read that never sees mem_ready
        set_req(0, 1'b0, 32'h44, 32'h0);
        drive();
        transfer(100);
        chk("err_sticky", 32'(bus.err), 1);
        // Reset in the second ACCESS cycle aborts the EXT read
        set_req(1, 1'b0, 32'h48, 32'h0);
        drive();
        bus.mem_ready = 1'b0;
        @(negedge clock);
        chk("abort_mem_en", 32'(bus.mem_en), 1);
        @(negedge clock);
        reset = 1'b1;
        pend[1] = 1'b0;
        drive();
        @(negedge clock);
        check_reset("abort");
        reset = 1'b0;
        rdata_exp[0] = '0;
        rdata_exp[1] = '0;
        err_exp = 1'b0;
        last = 1;
        set_req(0, 1'b0, 32'h40, 32'h0);
        set_req(1, 1'b0, 32'h100, 32'h0);
        drive();
        transfer(0);
        transfer(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max mem_ready wait cycles before abort.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 clock  in  1  single clock; all state changes on posedge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 cpu_req  in  1  CPU memory request, driven from the control unit enMem.
REQ-006 cpu_wr  in  1  CPU write (MemWrt); 0 = read.
REQ-007 cpu_addr  in  32  CPU address (MA register).
REQ-008 cpu_wdata  in  32  CPU write data (bus).
REQ-009 cpu_rdata  out  32  CPU read data, registered.
REQ-010 busy  out  1  stall to the control unit's Spin state.
REQ-011 ext_req / ext_wr  in  1 each  external requester (loader/debug) request and write flag.
REQ-012 ext_addr / ext_wdata  in  32 each  external address and write data.
REQ-013 ext_rdata  out  32  external read data, registered.
REQ-014 ext_ack  out  1  one-cycle completion pulse to the external requester.
REQ-015 mem_en / mem_wr  out  1 each  memory strobe and write enable.
REQ-016 mem_addr / mem_wdata  out  32 each  memory address and write data.
REQ-017 mem_rdata  in  32  memory read data; mem_ready  in  1  memory completion.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-020 IDLE: with any request present, the arbiter SHALL latch the winner's addr, wdata and wr, record the owner, and enter ACCESS on the next edge.
REQ-021 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins; last_grant updates at each grant.
REQ-022 ACCESS: mem_en=1, and mem_addr, mem_wdata and mem_wr SHALL be held stable from the latches.
REQ-023 ACCESS: mem_ready=1 SHALL go to RESP and capture mem_rdata into the owner's rdata register, for reads only.
REQ-024 The wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with mem_ready=0.
REQ-025 When the counter reaches TIMEOUT, the block SHALL go to RESP, set err=1, and for reads load ERR_DATA into the owner's rdata.
REQ-026 RESP lasts one cycle: owner CPU causes busy=0; owner EXT causes ext_ack=1. mem_en=0 in RESP and IDLE.
REQ-027 busy SHALL equal cpu_req AND NOT (state==RESP AND owner==CPU), combinationally.
REQ-028 Zero-wait latency: request sampled in IDLE at cycle N, mem_en at N+1, RESP and rdata valid at N+2.
REQ-029 rdata registers SHALL hold their value until the next completed read of the same requester; writes leave them unchanged.
REQ-030 A request dropped mid-ACCESS SHALL still complete on the memory side; its response pulse still occurs and is ignored.
REQ-031 Requests arriving during ACCESS or RESP SHALL wait; there is no preemption.
REQ-032 Back-to-back: a request still asserted in the IDLE cycle after RESP SHALL be arbitrated normally, giving a minimum 3-cycle spacing per transfer.
REQ-033 mem_ready in IDLE or RESP SHALL be ignored.

Reset
REQ-034 On reset: state=IDLE, owner=CPU, last_grant=EXT (the CPU wins the first tie), counter=0, err=0.
REQ-035 On reset: cpu_rdata=0, ext_rdata=0, ext_ack=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transfer at that edge, with no ack and no rdata update.

Structure
REQ-037 Shared package arb_pkg SHALL hold the FSM state encoding, the owner encoding (CPU/EXT), and the TIMEOUT and ERR_DATA defaults.
REQ-038 The counter SHALL be a sub-module wait_timer (clear, enable, TIMEOUT-reached output); all other logic is flat.

Verification
REQ-039 CPU read of 0x40 with mem_ready tied 1 and mem_rdata=0x12345678: mem_en high exactly 1 cycle; cpu_rdata=0x12345678 and busy=0 at N+2.
REQ-040 cpu_req and ext_req rise together right after reset: CPU granted first; EXT granted immediately after; ext_ack pulses once.
REQ-041 Both requesters held continuously for 6 transfers: grants alternate CPU, EXT, CPU, EXT, CPU, EXT.
REQ-042 CPU read with mem_ready never asserted, TIMEOUT=16: RESP after 16 ACCESS cycles; cpu_rdata=0xDEADBEEF; err=1 and stays 1.
REQ-043 EXT write of 0xA5A5A5A5 to 0x100 with mem_ready after 3 wait cycles: mem_addr and mem_wdata stable for 4 cycles; ext_rdata unchanged.
REQ-044 reset pulsed in the 2nd ACCESS cycle: next cycle all outputs at reset values and no ext_ack.
